// File: rtl/sdram_port_arbiter.sv
// Multi-port request arbiter in front of a single SDRAM controller, with an
// in-order read-tag FIFO that routes returning read data back to the issuing port.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// in place of round-robin arbitration.
module sdram_port_arbiter #(
  parameter int NPORT  = 2,
  parameter int DW     = 16,
  parameter int AW     = 24,
  parameter int ODEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req_valid,
  input  logic [NPORT-1:0]      req_write,
  input  logic [NPORT*AW-1:0]   req_addr,
  input  logic [NPORT*DW-1:0]   req_wdata,
  input  logic [NPORT*DW/8-1:0] req_byteenable,
  output logic [NPORT-1:0]      req_ready,
  output logic [NPORT-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  bus_req_valid,
  output logic                  bus_req_write,
  output logic [AW-1:0]         bus_req_addr,
  output logic [DW-1:0]         bus_req_wdata,
  output logic [DW/8-1:0]       bus_req_byteenable,
  input  logic                  bus_req_ready,
  input  logic                  bus_rsp_valid,
  input  logic [DW-1:0]         bus_rsp_rdata,
  output logic                  rsp_err
);

  localparam int BW   = DW / 8;
  localparam int TW   = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int PTRW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
  localparam int CW   = PTRW + 1;

  logic [TW-1:0]   tag_mem_q [ODEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;

  logic             fifo_full, fifo_empty;
  logic             accept, push, pop;
  logic [NPORT-1:0] eligible, grant;
  logic [TW-1:0]    gidx, start;

  assign fifo_full  = (cnt_q == CW'(ODEPTH));
  assign fifo_empty = (cnt_q == '0);

  // A full tag FIFO blocks reads even if a pop frees a slot this cycle.
  assign eligible = req_valid & (req_write | {NPORT{~fifo_full}});

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [TW-1:0] rr_ptr_q, rr_ptr_d;

  assign start = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gidx == TW'(NPORT - 1)) ? '0 : gidx + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    logic [TW:0]   sum;
    logic [TW-1:0] idx;
    logic          found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
      sum = {1'b0, start} + (TW+1)'(k);
      if (sum >= (TW+1)'(NPORT)) sum = sum - (TW+1)'(NPORT);
      idx = sum[TW-1:0];
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Grant is one-hot or zero, so an AND-OR mux yields a zero payload when idle.
  always_comb begin
    bus_req_write      = 1'b0;
    bus_req_addr       = '0;
    bus_req_wdata      = '0;
    bus_req_byteenable = '0;
    for (int i = 0; i < NPORT; i++) begin
      bus_req_write      = bus_req_write | (req_write[i] & grant[i]);
      bus_req_addr       = bus_req_addr | (req_addr[i*AW +: AW] & {AW{grant[i]}});
      bus_req_wdata      = bus_req_wdata | (req_wdata[i*DW +: DW] & {DW{grant[i]}});
      bus_req_byteenable = bus_req_byteenable | (req_byteenable[i*BW +: BW] & {BW{grant[i]}});
    end
  end

  assign bus_req_valid = |eligible;
  assign req_ready     = grant & {NPORT{bus_req_ready}};
  assign accept        = bus_req_valid & bus_req_ready;
  assign push          = accept & ~bus_req_write;
  assign pop           = bus_rsp_valid & ~fifo_empty;
  assign rsp_rdata     = bus_rsp_rdata;
  assign rsp_err       = rsp_err_q;

  always_comb begin
    rsp_valid = '0;
    if (pop) rsp_valid[tag_mem_q[rd_ptr_q]] = 1'b1;
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    rsp_err_d = rsp_err_q | (bus_rsp_valid & fifo_empty);
    cnt_d     = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gidx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule
